// File: rtl/decode_pipe.sv
// decode_pipe: RV32I decode + regfile + hazard stall + branch resolve + ID/EX register; DECODE_WB_BYPASS_EN adds write-back read bypass
module decode_pipe #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  localparam int RW = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [31:0]     id_instr,
  input  logic [XLEN-1:0] id_pc,
  input  logic            flush,
  input  logic            wb_we,
  input  logic [RW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            mem_reg_write,
  input  logic            mem_is_load,
  input  logic [RW-1:0]   mem_rd,
  input  logic [XLEN-1:0] mem_result,
  output logic            stall,
  output logic            pc_src,
  output logic [XLEN-1:0] pc_target,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [RW-1:0]   ex_rs1,
  output logic [RW-1:0]   ex_rs2,
  output logic [RW-1:0]   ex_rd,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_alu_src,
  output logic            ex_funct7b5,
  output logic [2:0]      ex_funct3,
  output logic            ex_link
);
  logic [XLEN-1:0] regs [NREGS];
  logic [6:0] opc;
  logic [2:0] f3;
  logic [RW-1:0] rs1, rs2, rd;
  logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc;
  logic known, use1, use2, wr;
  logic [XLEN-1:0] imm, rd1, rd2, b1, b2, jsum;
  logic ex_hit, mem_hit, load_use, br_haz, cond, taken, issue;
  assign opc = id_instr[6:0];
  assign f3 = id_instr[14:12];
  assign rd = id_instr[7 +: RW];
  assign rs1 = id_instr[15 +: RW];
  assign rs2 = id_instr[20 +: RW];
  assign is_r = opc == 7'b0110011;
  assign is_i = opc == 7'b0010011;
  assign is_ld = opc == 7'b0000011;
  assign is_st = opc == 7'b0100011;
  assign is_br = opc == 7'b1100011;
  assign is_jal = opc == 7'b1101111;
  assign is_jalr = opc == 7'b1100111;
  assign is_lui = opc == 7'b0110111;
  assign is_auipc = opc == 7'b0010111;
  assign known = is_r | is_i | is_ld | is_st | is_br | is_jal | is_jalr | is_lui | is_auipc;
  assign use1 = is_r | is_i | is_ld | is_st | is_br | is_jalr;
  assign use2 = is_r | is_st | is_br;
  assign wr = is_r | is_i | is_ld | is_jal | is_jalr | is_lui | is_auipc;
  assign imm = is_st ? XLEN'($signed({id_instr[31:25], id_instr[11:7]})) :
               is_br ? XLEN'($signed({id_instr[31], id_instr[7], id_instr[30:25], id_instr[11:8], 1'b0})) :
               is_jal ? XLEN'($signed({id_instr[31], id_instr[19:12], id_instr[20], id_instr[30:21], 1'b0})) :
               (is_lui | is_auipc) ? XLEN'($signed({id_instr[31:12], 12'b0})) :
               XLEN'($signed(id_instr[31:20]));
`ifdef DECODE_WB_BYPASS_EN
  assign rd1 = (rs1 == '0) ? '0 : (wb_we && wb_rd == rs1) ? wb_data : regs[rs1];
  assign rd2 = (rs2 == '0) ? '0 : (wb_we && wb_rd == rs2) ? wb_data : regs[rs2];
`else
  assign rd1 = (rs1 == '0) ? '0 : regs[rs1];
  assign rd2 = (rs2 == '0) ? '0 : regs[rs2];
`endif
  // Non-load MEM results are final, so branches can consume them without waiting for write-back
  assign b1 = (mem_reg_write && !mem_is_load && mem_rd != '0 && mem_rd == rs1) ? mem_result : rd1;
  assign b2 = (mem_reg_write && !mem_is_load && mem_rd != '0 && mem_rd == rs2) ? mem_result : rd2;
  assign cond = f3[2] ? (f3[1] ? (b1 < b2) : ($signed(b1) < $signed(b2))) : (b1 == b2);
  assign taken = is_br && (f3[2] || !f3[1]) && (cond ^ f3[0]);
  assign ex_hit = ex_rd != '0 && ((use1 && ex_rd == rs1) || (use2 && ex_rd == rs2));
  assign mem_hit = mem_rd != '0 && ((use1 && mem_rd == rs1) || (use2 && mem_rd == rs2));
  assign load_use = id_valid && ex_valid && ex_mem_read && ex_hit;
  assign br_haz = id_valid && (is_br || is_jalr) &&
                  ((ex_valid && ex_reg_write && ex_hit) || (mem_reg_write && mem_is_load && mem_hit));
  assign stall = (load_use || br_haz) && !flush;
  assign pc_src = id_valid && !stall && !flush && (is_jal || is_jalr || taken);
  assign jsum = b1 + imm;
  assign pc_target = is_jalr ? {jsum[XLEN-1:1], 1'b0} : id_pc + imm;
  assign issue = id_valid && known && !stall && !flush;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    else if (wb_we && wb_rd != '0)
      regs[wb_rd] <= wb_data;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid <= 1'b0;
      ex_pc <= '0;
      ex_imm <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_rs1 <= '0;
      ex_rs2 <= '0;
      ex_rd <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_alu_src <= 1'b0;
      ex_funct7b5 <= 1'b0;
      ex_funct3 <= '0;
      ex_link <= 1'b0;
    end else begin
      ex_valid <= issue;
      ex_pc <= id_pc;
      ex_imm <= imm;
      ex_rs1_data <= use1 ? rd1 : is_auipc ? id_pc : '0;
      ex_rs2_data <= rd2;
      ex_rs1 <= use1 ? rs1 : '0;
      ex_rs2 <= use2 ? rs2 : '0;
      ex_rd <= wr ? rd : '0;
      ex_reg_write <= issue && wr;
      ex_mem_read <= issue && is_ld;
      ex_mem_write <= issue && is_st;
      ex_alu_src <= issue && !(is_r || is_br);
      ex_funct7b5 <= issue && (is_r || (is_i && f3 == 3'b101)) && id_instr[30];
      ex_funct3 <= issue ? f3 : '0;
      ex_link <= issue && (is_jal || is_jalr);
    end
  end
endmodule
